// File: rtl/sysbus_mem_responder.sv
// Line-oriented memory target: READ returns BEATS words, WRITE absorbs BEATS words.
// Latency: header acked one cycle after sampling; first read beat LATENCY cycles after that ack.
// Backpressure: resp/resptag hold while respack=0; headers are not acked outside IDLE.
module sysbus_mem_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4,
    parameter int BEATS     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqcyc,
    input  logic [63:0] req,
    input  logic [12:0] reqtag,
    output logic        reqack,
    output logic        respcyc,
    output logic [63:0] resp,
    output logic [12:0] resptag,
    input  logic        respack
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [7:0]    LAT_LOAD  = 8'(LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_WAIT, S_RESP, S_WDATA} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   line_q, line_d;
    logic [12:0]     tag_q, tag_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [AW-1:0]   widx;
    logic            is_mem;
    logic            mem_we;

    // Backing store, deliberately not reset so contents survive a mid-transfer reset.
    logic [63:0] mem [MEM_WORDS];

    // Only the low line-index bits matter once the word index wraps.
    assign widx    = line_q * AW'(BEATS) + AW'(beat_q);
    assign is_mem  = (tag_q[11:8] == 4'b0001);
    assign resptag = tag_q;
    assign resp    = (respcyc && is_mem) ? mem[widx] : 64'h0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        reqack  = 1'b0;
        respcyc = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reqcyc) begin
                    line_d  = req[6 +: AW];
                    tag_d   = reqtag;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                reqack = 1'b1;
                beat_d = '0;
                if (tag_q[12]) begin
                    cnt_d = LAT_LOAD;
                    if (LATENCY <= 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WAIT: begin
                // Counter reaches zero on the edge that enters RESP.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                respcyc = 1'b1;
                if (respack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_WDATA: begin
                if (reqcyc) begin
                    reqack = 1'b1;
                    mem_we = is_mem;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder with a queue of expected read beats.
module tb_sysbus_mem_responder;
    localparam int MEM_WORDS = 4096;
    localparam int LATENCY   = 4;
    localparam int BEATS     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [63:0] model [MEM_WORDS];
    logic [63:0] exp_q [$];

    sysbus_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .LATENCY  (LATENCY),
        .BEATS    (BEATS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqcyc  (reqcyc),
        .req     (req),
        .reqtag  (reqtag),
        .reqack  (reqack),
        .respcyc (respcyc),
        .resp    (resp),
        .resptag (resptag),
        .respack (respack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reqack and respcyc must never overlap.
    always @(negedge clk) begin
        if (reset) begin
            n_cmp++;
            assert (!(reqack && respcyc)) else begin
                n_err++;
                $error("FAIL ack_resp_overlap observed reqack=%b respcyc=%b required not both", reqack, respcyc);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int widx_of(input logic [63:0] addr, input int b);
        return int'(((addr >> 6) * 64'(BEATS) + 64'(b)) % 64'(MEM_WORDS));
    endfunction

    task automatic send_header(input logic [63:0] addr, input logic [12:0] tag, input string name,
                               output int ack_at, output int acked);
        int w;
        w = 0;
        @(posedge clk); #1;
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        @(negedge clk);
        while (!reqack && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, " hdr_ack"}, 64'(reqack), 64'd1);
        acked  = reqack ? 1 : 0;
        ack_at = cyc;
        @(posedge clk); #1;
        reqcyc = 1'b0;
        req    = '0;
        @(negedge clk);
        check({name, " ack_one_cycle"}, 64'(reqack), 64'd0);
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [12:0] tag, input int stall_beat,
                             input int stall_n, input int abort_beat, input string name);
        int ack_at, acked, w;
        logic [63:0] e;
        for (int b = 0; b < BEATS; b++) begin
            exp_q.push_back((tag[11:8] == 4'b0001) ? model[widx_of(addr, b)] : 64'h0);
        end
        send_header(addr, tag, name, ack_at, acked);
        for (int b = 0; b < BEATS; b++) begin
            w = 0;
            @(negedge clk);
            while (!respcyc && w < 40) begin
                @(negedge clk);
                w++;
            end
            check({name, " respcyc"}, 64'(respcyc), 64'd1);
            if (b == 0) check({name, " latency"}, 64'(cyc - ack_at), 64'(LATENCY));
            check({name, " resptag"}, 64'(resptag), 64'(tag));
            if (b == abort_beat) begin
                reset = 1'b0;
                #1;
                check({name, " rst_respcyc"}, 64'(respcyc), 64'd0);
                check({name, " rst_reqack"}, 64'(reqack), 64'd0);
                check({name, " rst_resp"}, resp, 64'h0);
                check({name, " rst_resptag"}, 64'(resptag), 64'h0);
                exp_q.delete();
                @(negedge clk);
                check({name, " rst_quiet"}, 64'(respcyc), 64'd0);
                reset = 1'b1;
                return;
            end
            if (b == stall_beat) begin
                respack = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    check({name, " stall_valid"}, 64'(respcyc), 64'd1);
                    check({name, " stall_hold"}, resp, exp_q[0]);
                    check({name, " stall_tag"}, 64'(resptag), 64'(tag));
                end
                respack = 1'b1;
            end
            e = exp_q.pop_front();
            check({name, " beat"}, resp, e);
        end
        @(negedge clk);
        check({name, " done_idle"}, 64'(respcyc), 64'd0);
        check({name, " queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base,
                              input int gap_beat, input string name);
        int ack_at, acks;
        send_header(addr, tag, name, ack_at, acks);
        for (int b = 0; b < BEATS; b++) begin
            if (b == gap_beat) begin
                @(posedge clk); #1;
                reqcyc = 1'b0;
                @(negedge clk);
                check({name, " gap_noack"}, 64'(reqack), 64'd0);
            end
            @(posedge clk); #1;
            reqcyc = 1'b1;
            req    = base + 64'(b);
            @(negedge clk);
            check({name, " data_ack"}, 64'(reqack), 64'd1);
            if (reqack) acks++;
            if (tag[11:8] == 4'b0001) model[widx_of(addr, b)] = base + 64'(b);
        end
        @(posedge clk); #1;
        reqcyc = 1'b0;
        req    = '0;
        @(negedge clk);
        check({name, " ack_total"}, 64'(acks), 64'(BEATS + 1));
        check({name, " no_resp"}, 64'(respcyc), 64'd0);
    endtask

    initial begin
        reset   = 1'b0;
        reqcyc  = 1'b0;
        req     = '0;
        reqtag  = '0;
        respack = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) model[i] = 64'h0;
        for (int i = 0; i < 8; i++) begin
            model[i]       = 64'h500 + 64'(i);
            model[8 + i]   = 64'h1000 + 64'(i);
            dut.mem[i]     = model[i];
            dut.mem[8 + i] = model[8 + i];
        end
        repeat (3) @(negedge clk);
        check("reset reqack", 64'(reqack), 64'd0);
        check("reset respcyc", 64'(respcyc), 64'd0);
        check("reset resp", resp, 64'h0);
        check("reset resptag", 64'(resptag), 64'h0);
        reset = 1'b1;

        read_line(64'h40, 13'h1100, -1, 0, -1, "rd40");
        read_line(64'h40, 13'h1100, 2, 3, -1, "rd40_stall");
        write_line(64'h80, 13'h0101, 64'hA0, 5, "wr80");
        read_line(64'h80, 13'h1102, -1, 0, -1, "rd80");
        read_line(64'h7F, 13'h1103, -1, 0, -1, "rd7f");
        read_line(64'(MEM_WORDS * 8), 13'h1104, -1, 0, -1, "rd_wrap");
        read_line(64'h40, 13'h1205, -1, 0, -1, "rd_tgt2");
        write_line(64'h40, 13'h0206, 64'hDEAD0, -1, "wr_tgt2");
        read_line(64'h40, 13'h1107, -1, 0, 3, "rd_reset");
        for (int i = 0; i < 24; i++) begin
            check("store_kept", dut.mem[i], model[i]);
        end
        read_line(64'h40, 13'h1108, -1, 0, -1, "rd_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
